// File: rtl/exu_alu_arb_pkg.sv
// Shared definitions for the EXU ALU arbiter: datapath widths, one-hot ALU op
// bit positions, buffer state encoding and the buffered-result record.
package exu_alu_arb_pkg;

  localparam int XLEN  = 32;
  localparam int OP_W  = 5;
  localparam int TAG_W = 4;

  // Bit positions within the one-hot ALU op select.
  localparam int ALU_ADD  = 0;
  localparam int ALU_XOR  = 1;
  localparam int ALU_OR   = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_LUI  = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

  typedef struct packed {
    logic             src;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  wdat;
  } rsp_t;

endpackage

// File: rtl/exu_alu_arb_if.sv
// Bus bundle between the two EXU requesters, the shared ALU and writeback.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface exu_alu_arb_if;
  import exu_alu_arb_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [OP_W-1:0]  req0_op;
  logic [XLEN-1:0]  req0_op1;
  logic [XLEN-1:0]  req0_op2;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [OP_W-1:0]  req1_op;
  logic [XLEN-1:0]  req1_op1;
  logic [XLEN-1:0]  req1_op2;
  logic [TAG_W-1:0] req1_tag;

  logic [OP_W-1:0]  alu_op;
  logic [XLEN-1:0]  alu_op1;
  logic [XLEN-1:0]  alu_op2;
  logic [XLEN-1:0]  alu_res;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_src;
  logic [TAG_W-1:0] rsp_tag;
  logic [XLEN-1:0]  rsp_wdat;

  modport slave (
    input  req0_valid, req0_op, req0_op1, req0_op2, req0_tag,
    output req0_ready,
    input  req1_valid, req1_op, req1_op1, req1_op2, req1_tag,
    output req1_ready,
    output alu_op, alu_op1, alu_op2,
    input  alu_res,
    output rsp_valid, rsp_src, rsp_tag, rsp_wdat,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_op1, req0_op2, req0_tag,
    input  req0_ready,
    output req1_valid, req1_op, req1_op1, req1_op2, req1_tag,
    input  req1_ready,
    input  alu_op, alu_op1, alu_op2,
    output alu_res,
    input  rsp_valid, rsp_src, rsp_tag, rsp_wdat,
    output rsp_ready
  );

endinterface

// File: rtl/exu_alu_rr_arb2.sv
// Two-way round-robin picker; purely combinational, the pointer lives in the
// parent. rr_ptr names the requester that wins when both are valid.
module exu_alu_rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic rr_ptr,
  output logic grant0,
  output logic grant1
);

  assign grant0 = valid0 & (~valid1 | ~rr_ptr);
  assign grant1 = valid1 & (~valid0 |  rr_ptr);

endmodule

// File: rtl/exu_alu_arb.sv
// Shares one ALU between two EXU requesters with round-robin arbitration and
// a one-entry result buffer. Optional counters: define EXU_ALU_ARB_PERF_EN.
module exu_alu_arb
  import exu_alu_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  exu_alu_arb_if.slave  bus
`ifdef EXU_ALU_ARB_PERF_EN
  ,
  output logic [31:0]   perf_grant0,
  output logic [31:0]   perf_grant1,
  output logic [31:0]   perf_stall
`endif
);

  buf_state_e state_q, state_d;
  logic       rr_ptr_q;
  rsp_t       rsp_q;

  logic grant0, grant1;
  logic accept;
  logic hs0, hs1, hs;

  exu_alu_rr_arb2 u_rr_arb2 (
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .rr_ptr (rr_ptr_q),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  // A draining buffer can take a new result in the same cycle.
  assign accept = (state_q == ST_EMPTY) | bus.rsp_ready;
  assign hs0    = accept & grant0;
  assign hs1    = accept & grant1;
  assign hs     = hs0 | hs1;

  assign bus.req0_ready = hs0;
  assign bus.req1_ready = hs1;

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.alu_op  = '0;
    bus.alu_op1 = '0;
    bus.alu_op2 = '0;
    if (grant0) begin
      bus.alu_op  = bus.req0_op;
      bus.alu_op1 = bus.req0_op1;
      bus.alu_op2 = bus.req0_op2;
    end else if (grant1) begin
      bus.alu_op  = bus.req1_op;
      bus.alu_op1 = bus.req1_op1;
      bus.alu_op2 = bus.req1_op2;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (hs) state_d = ST_FULL;
      ST_FULL:  if (!hs && bus.rsp_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= 1'b0;
      rsp_q    <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        rsp_q    <= '{src:  hs1,
                      tag:  hs1 ? bus.req1_tag : bus.req0_tag,
                      wdat: bus.alu_res};
        rr_ptr_q <= hs0;
      end
    end
  end

  assign bus.rsp_valid = (state_q == ST_FULL);
  assign bus.rsp_src   = rsp_q.src;
  assign bus.rsp_tag   = rsp_q.tag;
  assign bus.rsp_wdat  = rsp_q.wdat;

`ifdef EXU_ALU_ARB_PERF_EN
  logic any_valid;
  assign any_valid = bus.req0_valid | bus.req1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall  <= '0;
    end else begin
      if (hs0) perf_grant0 <= perf_grant0 + 32'd1;
      if (hs1) perf_grant1 <= perf_grant1 + 32'd1;
      if (any_valid && !hs) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exu_alu_arb.sv
// Directed bench for exu_alu_arb with a behavioural ALU and a result
// scoreboard; counter checks are included when EXU_ALU_ARB_PERF_EN is set.
module tb_exu_alu_arb;
  import exu_alu_arb_pkg::*;

  typedef struct {
    logic             v;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
  } req_t;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00001;
  localparam logic [OP_W-1:0] OP_XOR  = 5'b00010;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00100;
  localparam logic [OP_W-1:0] OP_SLTU = 5'b01000;
  localparam logic [OP_W-1:0] OP_LUI  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NONE = 5'b00000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exu_alu_arb_if bus ();

`ifdef EXU_ALU_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_stall;
  int unsigned exp_g0, exp_g1, exp_stall;
`endif

  exu_alu_arb dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave)
`ifdef EXU_ALU_ARB_PERF_EN
    ,
    .perf_grant0 (perf_grant0),
    .perf_grant1 (perf_grant1),
    .perf_stall  (perf_stall)
`endif
  );

  function automatic logic [XLEN-1:0] alu_model(input logic [OP_W-1:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_LUI:  return b;
      default: return '0;
    endcase
  endfunction

  assign bus.alu_res = alu_model(bus.alu_op, bus.alu_op1, bus.alu_op2);

  rsp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic req_t mk(input logic v, input logic [OP_W-1:0] op,
                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                              input logic [TAG_W-1:0] tag);
    req_t r;
    r.v = v; r.op = op; r.a = a; r.b = b; r.tag = tag;
    return r;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic drive(input req_t r0, input req_t r1, input logic rdy);
    bus.req0_valid = r0.v;  bus.req0_op = r0.op;  bus.req0_op1 = r0.a;
    bus.req0_op2   = r0.b;  bus.req0_tag = r0.tag;
    bus.req1_valid = r1.v;  bus.req1_op = r1.op;  bus.req1_op1 = r1.a;
    bus.req1_op2   = r1.b;  bus.req1_tag = r1.tag;
    bus.rsp_ready  = rdy;
  endtask

  // One clock of stimulus: drive, check mid-cycle, then update the model at the edge.
  task automatic step(input string name, input req_t r0, input req_t r1,
                      input logic rdy, input logic e0, input logic e1);
    rsp_t exp_r;
    drive(r0, r1, rdy);
    @(negedge clk);
    check({name, ".req0_ready"}, {31'd0, bus.req0_ready}, {31'd0, e0});
    check({name, ".req1_ready"}, {31'd0, bus.req1_ready}, {31'd0, e1});
    if (e0) begin
      check({name, ".alu_op1"}, bus.alu_op1, r0.a);
      check({name, ".alu_op"},  {27'd0, bus.alu_op}, {27'd0, r0.op});
    end else if (e1) begin
      check({name, ".alu_op1"}, bus.alu_op1, r1.a);
      check({name, ".alu_op"},  {27'd0, bus.alu_op}, {27'd0, r1.op});
    end else if (!r0.v && !r1.v) begin
      check({name, ".alu_idle"}, {27'd0, bus.alu_op} | bus.alu_op1 | bus.alu_op2, '0);
    end
    check({name, ".rsp_valid"}, {31'd0, bus.rsp_valid}, {31'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      check({name, ".rsp_src"},  {31'd0, bus.rsp_src},  {31'd0, sb[0].src});
      check({name, ".rsp_tag"},  {28'd0, bus.rsp_tag},  {28'd0, sb[0].tag});
      check({name, ".rsp_wdat"}, bus.rsp_wdat, sb[0].wdat);
    end
    @(posedge clk);
    if (sb.size() != 0 && rdy) void'(sb.pop_front());
    if (e0) begin
      exp_r = '{src: 1'b0, tag: r0.tag, wdat: alu_model(r0.op, r0.a, r0.b)};
      sb.push_back(exp_r);
    end
    if (e1) begin
      exp_r = '{src: 1'b1, tag: r1.tag, wdat: alu_model(r1.op, r1.a, r1.b)};
      sb.push_back(exp_r);
    end
`ifdef EXU_ALU_ARB_PERF_EN
    if (e0) exp_g0++;
    if (e1) exp_g1++;
    if ((r0.v || r1.v) && !e0 && !e1) exp_stall++;
`endif
    #1;
  endtask

  task automatic check_reset_state(input string name);
    check({name, ".rsp_valid"}, {31'd0, bus.rsp_valid}, '0);
    check({name, ".rsp_src"},   {31'd0, bus.rsp_src},   '0);
    check({name, ".rsp_tag"},   {28'd0, bus.rsp_tag},   '0);
    check({name, ".rsp_wdat"},  bus.rsp_wdat,           '0);
`ifdef EXU_ALU_ARB_PERF_EN
    check({name, ".perf_grant0"}, perf_grant0, '0);
    check({name, ".perf_grant1"}, perf_grant1, '0);
    check({name, ".perf_stall"},  perf_stall,  '0);
`endif
  endtask

  initial begin
    req_t idle;
    idle = mk(1'b0, OP_NONE, '0, '0, '0);
    rst  = 1'b1;
    drive(idle, idle, 1'b0);
`ifdef EXU_ALU_ARB_PERF_EN
    exp_g0 = 0; exp_g1 = 0; exp_stall = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    // Single add, then drain.
    step("add",   mk(1, OP_ADD, 3, 4, 5), idle, 1'b1, 1'b1, 1'b0);
    step("drain", idle, idle, 1'b1, 1'b0, 1'b0);
    step("solo1", idle, mk(1, OP_OR, 32'h0A, 32'h50, 2), 1'b1, 1'b0, 1'b1);

    // Both requesters contend: grants alternate 0,1,0,1 back to back.
    step("rr_a", mk(1, OP_ADD, 100, 23, 6), mk(1, OP_SLTU, 1, 2, 3), 1'b1, 1'b1, 1'b0);
    step("rr_b", mk(1, OP_ADD, 7, 8, 7),    mk(1, OP_SLTU, 1, 2, 3), 1'b1, 1'b0, 1'b1);
    step("rr_c", mk(1, OP_ADD, 7, 8, 7),    mk(1, OP_SLTU, 5, 2, 4), 1'b1, 1'b1, 1'b0);
    step("rr_d", mk(1, OP_LUI, 0, 32'h12345000, 8), mk(1, OP_SLTU, 5, 2, 4), 1'b1, 1'b0, 1'b1);
    step("lui",  mk(1, OP_LUI, 0, 32'h12345000, 8), idle, 1'b1, 1'b1, 1'b0);

    // Stall with req1 waiting, then drain-and-refill in one cycle.
    for (int i = 0; i < 3; i++)
      step("stall", idle, mk(1, OP_XOR, 32'hF0, 32'h0F, 9), 1'b0, 1'b0, 1'b0);
    step("refill", idle, mk(1, OP_XOR, 32'hF0, 32'h0F, 9), 1'b1, 1'b0, 1'b1);
    step("xor_out", idle, idle, 1'b1, 1'b0, 1'b0);
    step("empty",   idle, idle, 1'b0, 1'b0, 1'b0);

    // Empty buffer accepts without rsp_ready; zero op yields the nop result.
    step("zero_op", mk(1, OP_NONE, 32'hDEAD, 32'hBEEF, 10), idle, 1'b0, 1'b1, 1'b0);
    step("full_stall", idle, mk(1, OP_ADD, 1, 1, 11), 1'b0, 1'b0, 1'b0);

`ifdef EXU_ALU_ARB_PERF_EN
    check("perf_grant0", perf_grant0, exp_g0);
    check("perf_grant1", perf_grant1, exp_g1);
    check("perf_stall",  perf_stall,  exp_stall);
`endif

    // Reset while full with the pointer at requester 1.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
`ifdef EXU_ALU_ARB_PERF_EN
    exp_g0 = 0; exp_g1 = 0; exp_stall = 0;
`endif
    check_reset_state("mid_reset");
    step("post_rst_a", mk(1, OP_ADD, 2, 3, 12), mk(1, OP_ADD, 1, 1, 11), 1'b1, 1'b1, 1'b0);
    step("post_rst_b", idle, mk(1, OP_ADD, 1, 1, 11), 1'b1, 1'b0, 1'b1);
    step("post_rst_c", idle, idle, 1'b1, 1'b0, 1'b0);
    step("post_rst_d", idle, idle, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
